// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Drives an N-digit common-segment multiplexed 7-segment display.
//   - A scan counter gives each digit a slot of CLKS_PER_DIGIT cycles. The
//     first DEAD_CLKS cycles of every slot have no digit selected and all
//     segments unlit, so the previous digit's pattern does not ghost onto
//     the next one.
//   - Nibbles are encoded as hex (or as a dash above 9 in decimal mode).
//     Leading zeros are optionally blanked. Each digit has a decimal point.
//   - The displayed value is double-buffered. A load lands in a pending
//     buffer, and the pending buffer moves to the display buffer only at a
//     frame boundary. A frame never mixes an old value with a new one.
//   - All display outputs are registered. They reflect the (counter, index)
//     pair of the previous cycle.
//
// i_Load is a single-cycle strobe with no back-pressure. There is no
// valid/ready pair: every cycle on which i_Load is high is accepted.
//
// Ports
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Value        digit nibbles, [3:0] = digit 0 (rightmost)
//   i_Dp           decimal point per digit, 1 = lit
//   i_Load         capture i_Value / i_Dp into the pending buffer
//   i_Dec_Mode     1 = nibbles above 9 shown as a dash (segment G)
//   i_Blank_En     1 = leading-zero blanking enabled
//   o_Segment_A..G segment drives (polarity set by SEG_ACTIVE_LOW)
//   o_Segment_DP   decimal point drive (polarity set by SEG_ACTIVE_LOW)
//   o_Digit_En     digit selects (polarity set by DIG_ACTIVE_LOW)
//   o_Frame_Done   one-cycle pulse in the cycle after the last slot ends
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Load,
  input  logic                    i_Dec_Mode,
  input  logic                    i_Blank_En,
  output logic                    o_Segment_A,
  output logic                    o_Segment_B,
  output logic                    o_Segment_C,
  output logic                    o_Segment_D,
  output logic                    o_Segment_E,
  output logic                    o_Segment_F,
  output logic                    o_Segment_G,
  output logic                    o_Segment_DP,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Done
);

  localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Unlit / deselected output levels. XOR with these constants applies the
  // board polarity to an active-high internal pattern.
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  // Segment patterns, bit6 = A ... bit0 = G, active high.
  localparam logic [6:0] SEG_DASH = 7'h01;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h7E;
      4'h1:    hex_to_seg = 7'h30;
      4'h2:    hex_to_seg = 7'h6D;
      4'h3:    hex_to_seg = 7'h79;
      4'h4:    hex_to_seg = 7'h33;
      4'h5:    hex_to_seg = 7'h5B;
      4'h6:    hex_to_seg = 7'h5F;
      4'h7:    hex_to_seg = 7'h70;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h7B;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h1F;
      4'hC:    hex_to_seg = 7'h4E;
      4'hD:    hex_to_seg = 7'h3D;
      4'hE:    hex_to_seg = 7'h4F;
      4'hF:    hex_to_seg = 7'h47;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic             cnt_term;
  logic             idx_last;
  logic             frame_end;
  logic             in_dead;

  assign cnt_term  = (scan_cnt == CNT_LAST);
  assign idx_last  = (dig_idx == IDX_LAST);
  assign frame_end = cnt_term && idx_last;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (cnt_term) begin
      scan_cnt <= '0;
      dig_idx  <= idx_last ? '0 : dig_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // With no dead-time the comparison would be constant, so it is left out.
  generate
    if (DEAD_CLKS == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (scan_cnt < CNT_W'(DEAD_CLKS));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending / display buffers
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pend_value <= '0;
      pend_dp    <= '0;
    end else if (i_Load) begin
      pend_value <= i_Value;
      pend_dp    <= i_Dp;
    end
  end

  // A load on the frame-end cycle bypasses pending. Otherwise it would sit
  // there for a whole extra frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      disp_value <= '0;
      disp_dp    <= '0;
    end else if (frame_end) begin
      disp_value <= i_Load ? i_Value : pend_value;
      disp_dp    <= i_Load ? i_Dp    : pend_dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection
  // A digit is a leading zero when it and every more significant digit are
  // zero. Digit 0 is excluded so that a value of 0 still shows "0".
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (disp_value[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run && (k != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit selection and encoding
  // ---------------------------------------------------------------------------
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lead_zero;
  logic [NUM_DIGITS-1:0] dig_onehot;
  logic [6:0]            cur_seg;

  always_comb begin
    cur_nib       = 4'h0;
    cur_dp        = 1'b0;
    cur_lead_zero = 1'b0;
    dig_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx == IDX_W'(k)) begin
        cur_nib       = disp_value[4*k +: 4];
        cur_dp        = disp_dp[k];
        cur_lead_zero = lead_zero[k];
        dig_onehot[k] = 1'b1;
      end
    end
  end

  // Blanking wins over the dash, but a dash digit is nonzero and so can
  // never be a leading zero anyway.
  always_comb begin
    if (i_Blank_En && cur_lead_zero) begin
      cur_seg = 7'h00;
    end else if (i_Dec_Mode && (cur_nib > 4'd9)) begin
      cur_seg = SEG_DASH;
    end else begin
      cur_seg = hex_to_seg(cur_nib);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Polarity is applied before the register, so the
  // pins come straight from flops.
  // ---------------------------------------------------------------------------
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] dig_en_q;
  logic                  frame_done_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_en_q     <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (in_dead) begin
        seg_q    <= SEG_OFF;
        dp_q     <= DP_OFF;
        dig_en_q <= DIG_OFF;
      end else begin
        seg_q    <= cur_seg ^ SEG_OFF;
        dp_q     <= cur_dp ^ DP_OFF;
        dig_en_q <= dig_onehot ^ DIG_OFF;
      end
    end
  end

  assign o_Segment_A  = seg_q[6];
  assign o_Segment_B  = seg_q[5];
  assign o_Segment_C  = seg_q[4];
  assign o_Segment_D  = seg_q[3];
  assign o_Segment_E  = seg_q[2];
  assign o_Segment_F  = seg_q[1];
  assign o_Segment_G  = seg_q[0];
  assign o_Segment_DP = dp_q;
  assign o_Digit_En   = dig_en_q;
  assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Three instances share one stimulus:
//   dut_main : 4 digits, 4 clocks per slot, 1 dead clock, default polarity
//   dut_pol  : same geometry, active-low segments, active-high digit enables
//   dut_one  : 1 digit, 3 clocks per slot, no dead-time
//
// The reference model works from the scan position counted since reset
// release. The position gives the slot, the digit and the dead-time by
// division and modulo. The expected buffer contents are tracked as plain
// values.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL timeout sim_time=%0t limit=200us", $time);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus and DUT wiring
  // ---------------------------------------------------------------------------
  logic [15:0] value = 16'h0;
  logic [3:0]  dp    = 4'h0;
  logic        load  = 1'b0;
  logic        dec   = 1'b0;
  logic        blank = 1'b0;

  logic m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_dp, m_fd;
  logic [3:0] m_en;
  logic p_a, p_b, p_c, p_d, p_e, p_f, p_g, p_dp, p_fd;
  logic [3:0] p_en;
  logic o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_dp, o_fd;
  logic [0:0] o_en;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .DEAD_CLKS(1),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_main (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(value), .i_Dp(dp), .i_Load(load),
    .i_Dec_Mode(dec), .i_Blank_En(blank),
    .o_Segment_A(m_a), .o_Segment_B(m_b), .o_Segment_C(m_c), .o_Segment_D(m_d),
    .o_Segment_E(m_e), .o_Segment_F(m_f), .o_Segment_G(m_g),
    .o_Segment_DP(m_dp), .o_Digit_En(m_en), .o_Frame_Done(m_fd)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .DEAD_CLKS(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
  ) dut_pol (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(value), .i_Dp(dp), .i_Load(load),
    .i_Dec_Mode(dec), .i_Blank_En(blank),
    .o_Segment_A(p_a), .o_Segment_B(p_b), .o_Segment_C(p_c), .o_Segment_D(p_d),
    .o_Segment_E(p_e), .o_Segment_F(p_f), .o_Segment_G(p_g),
    .o_Segment_DP(p_dp), .o_Digit_En(p_en), .o_Frame_Done(p_fd)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(1), .CLKS_PER_DIGIT(3), .DEAD_CLKS(0),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_one (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(value[3:0]), .i_Dp(dp[0:0]),
    .i_Load(load), .i_Dec_Mode(dec), .i_Blank_En(blank),
    .o_Segment_A(o_a), .o_Segment_B(o_b), .o_Segment_C(o_c), .o_Segment_D(o_d),
    .o_Segment_E(o_e), .o_Segment_F(o_f), .o_Segment_G(o_g),
    .o_Segment_DP(o_dp), .o_Digit_En(o_en), .o_Frame_Done(o_fd)
  );

  logic [6:0]  m_seg, p_seg, o_seg;
  logic [12:0] act_main, act_pol;
  logic [9:0]  act_one;
  assign m_seg    = {m_a, m_b, m_c, m_d, m_e, m_f, m_g};
  assign p_seg    = {p_a, p_b, p_c, p_d, p_e, p_f, p_g};
  assign o_seg    = {o_a, o_b, o_c, o_d, o_e, o_f, o_g};
  assign act_main = {m_seg, m_dp, m_en, m_fd};
  assign act_pol  = {p_seg, p_dp, p_en, p_fd};
  assign act_one  = {o_seg, o_dp, o_en, o_fd};

  localparam logic [12:0] RST_MAIN = {7'h00, 1'b0, 4'hF, 1'b0};
  localparam logic [12:0] RST_POL  = {7'h7F, 1'b1, 4'h0, 1'b0};
  localparam logic [9:0]  RST_ONE  = {7'h00, 1'b0, 1'b1, 1'b0};

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                              7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                              7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          pos_m, pos_1;
  logic [15:0] pend_m, disp_m;
  logic [3:0]  pdp_m, ddp_m;
  logic [3:0]  pend_1, disp_1;
  logic        pdp_1, ddp_1;
  logic [12:0] exp_main, exp_pol;
  logic [9:0]  exp_one;

  // Digit k of v is blank when v shifted down by k digits is zero.
  function automatic logic [6:0] seg_of(input logic [15:0] v, input int k,
                                        input logic d, input logic b);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * k);
    nib   = upper[3:0];
    if (b && (k != 0) && (upper == 16'h0)) return 7'h00;
    if (d && (nib > 4'd9)) return 7'h01;
    return seg_tbl[nib];
  endfunction

  task automatic model_reset();
    pos_m = 0; pend_m = '0; disp_m = '0; pdp_m = '0; ddp_m = '0;
    pos_1 = 0; pend_1 = '0; disp_1 = '0; pdp_1 = 1'b0; ddp_1 = 1'b0;
    exp_main = RST_MAIN; exp_pol = RST_POL; exp_one = RST_ONE;
  endtask

  // One clock: the expected outputs come from the position and buffers
  // before the edge. The buffers are then updated. Returns at the next
  // falling edge, where outputs are sampled and inputs are changed.
  task automatic tick();
    int         cnt, dig;
    logic       act, fd, dv;
    logic [6:0] s;
    logic [3:0] en;
    @(posedge clk);
    if (rst_n) begin
      cnt = pos_m % 4;
      dig = (pos_m / 4) % 4;
      act = (cnt >= 1);
      fd  = ((pos_m % 16) == 15);
      s   = act ? seg_of(disp_m, dig, dec, blank) : 7'h00;
      dv  = act ? ddp_m[dig] : 1'b0;
      en  = act ? 4'(1 << dig) : 4'h0;
      exp_main = {s, dv, ~en, fd};
      exp_pol  = {~s, ~dv, en, fd};
      if (fd) begin
        disp_m = load ? value : pend_m;
        ddp_m  = load ? dp : pdp_m;
      end
      if (load) begin
        pend_m = value;
        pdp_m  = dp;
      end
      pos_m++;

      fd = ((pos_1 % 3) == 2);
      exp_one = {seg_of({12'h0, disp_1}, 0, dec, blank), ddp_1, 1'b0, fd};
      if (fd) begin
        disp_1 = load ? value[3:0] : pend_1;
        ddp_1  = load ? dp[0] : pdp_1;
      end
      if (load) begin
        pend_1 = value[3:0];
        pdp_1  = dp[0];
      end
      pos_1++;
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the next output cycle is the first slot of a frame.
  task automatic sync_frame();
    while ((pos_m % 16) != 0) tick();
  endtask

  logic [6:0] got_m [4];
  logic [6:0] got_p [4];
  logic       gdp_m [4];

  // One frame. Each digit's segments are recorded from whichever cycles
  // show that digit selected.
  task automatic capture_frame();
    for (int k = 0; k < 4; k++) begin
      got_m[k] = 'x; got_p[k] = 'x; gdp_m[k] = 1'bx;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (m_en == ~(4'b0001 << k)) begin got_m[k] = m_seg; gdp_m[k] = m_dp; end
        if (p_en == (4'b0001 << k)) got_p[k] = p_seg;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int d0_cnt, fd_cnt, first_fd;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (act_main !== RST_MAIN) begin tests_failed++; $display("FAIL reset_hold main got=%h exp=%h", act_main, RST_MAIN); end
      tests_run++;
      if (act_pol !== RST_POL) begin tests_failed++; $display("FAIL reset_hold pol got=%h exp=%h", act_pol, RST_POL); end
      tests_run++;
      if (act_one !== RST_ONE) begin tests_failed++; $display("FAIL reset_hold one got=%h exp=%h", act_one, RST_ONE); end
    end
    rst_n = 1'b1;
    d0_cnt = 0; fd_cnt = 0; first_fd = -1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i < 4 && m_en == 4'b1110) d0_cnt++;
      if (m_fd === 1'b1) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = i + 1;
      end
      tests_run++;
      if (act_main !== exp_main) begin tests_failed++; $display("FAIL reset_scan main cyc=%0d got=%h exp=%h", i, act_main, exp_main); end
      tests_run++;
      if (act_pol !== exp_pol) begin tests_failed++; $display("FAIL reset_scan pol cyc=%0d got=%h exp=%h", i, act_pol, exp_pol); end
      tests_run++;
      if (act_one !== exp_one) begin tests_failed++; $display("FAIL reset_scan one cyc=%0d got=%h exp=%h", i, act_one, exp_one); end
    end
    tests_run++;
    if (d0_cnt !== 3) begin tests_failed++; $display("FAIL digit0_slot got=%0d cycles exp=3", d0_cnt); end
    tests_run++;
    if (fd_cnt !== 2) begin tests_failed++; $display("FAIL frame_done_count got=%0d exp=2", fd_cnt); end
    tests_run++;
    if (first_fd !== 16) begin tests_failed++; $display("FAIL frame_done_first got=%0d exp=16", first_fd); end
  endtask

  task automatic test_table();
    logic [6:0] hex_exp [4];
    logic [6:0] dec_exp [4];
    hex_exp = '{7'h7E, 7'h47, 7'h1F, 7'h70};
    dec_exp = '{7'h7E, 7'h01, 7'h01, 7'h70};
    dec = 1'b0; blank = 1'b0;
    load_pulse(16'h7BF0, 4'h0);
    sync_frame();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_m[k] !== hex_exp[k]) begin tests_failed++; $display("FAIL table_hex d%0d got=%h exp=%h", k, got_m[k], hex_exp[k]); end
    end
    dec = 1'b1;
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_m[k] !== dec_exp[k]) begin tests_failed++; $display("FAIL table_dec d%0d got=%h exp=%h", k, got_m[k], dec_exp[k]); end
    end
    dec = 1'b0;
  endtask

  task automatic test_blanking();
    logic [15:0] vals [3];
    logic [6:0]  exps [3][4];
    vals = '{16'h0005, 16'h0000, 16'h0105};
    exps = '{'{7'h5B, 7'h00, 7'h00, 7'h00},
             '{7'h7E, 7'h00, 7'h00, 7'h00},
             '{7'h5B, 7'h7E, 7'h30, 7'h00}};
    blank = 1'b1;
    for (int v = 0; v < 3; v++) begin
      load_pulse(vals[v], 4'h0);
      sync_frame();
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (got_m[k] !== exps[v][k]) begin tests_failed++; $display("FAIL blank_%h d%0d got=%h exp=%h", vals[v], k, got_m[k], exps[v][k]); end
      end
    end
  endtask

  task automatic test_frame_buffer();
    logic [6:0] mid [4];
    blank = 1'b0;
    // Display holds 0105. A mid-frame load must not reach digits 2/3 of
    // the frame in progress.
    sync_frame();
    for (int i = 0; i < 5; i++) tick();
    load_pulse(16'h1111, 4'h0);
    mid[2] = 'x; mid[3] = 'x;
    while ((pos_m % 16) != 0) begin
      tick();
      if (m_en == 4'b1011) mid[2] = m_seg;
      if (m_en == 4'b0111) mid[3] = m_seg;
    end
    tests_run++;
    if (mid[2] !== 7'h30) begin tests_failed++; $display("FAIL midframe d2 got=%h exp=30", mid[2]); end
    tests_run++;
    if (mid[3] !== 7'h7E) begin tests_failed++; $display("FAIL midframe d3 got=%h exp=7e", mid[3]); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_m[k] !== 7'h30) begin tests_failed++; $display("FAIL next_frame_1111 d%0d got=%h exp=30", k, got_m[k]); end
    end
    // Load exactly on the frame-end edge.
    while ((pos_m % 16) != 15) tick();
    load_pulse(16'h2222, 4'h0);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_m[k] !== 7'h6D) begin tests_failed++; $display("FAIL frame_end_load d%0d got=%h exp=6d", k, got_m[k]); end
    end
    // Two loads within one frame: the later one is shown.
    for (int i = 0; i < 2; i++) tick();
    load_pulse(16'h3333, 4'h0);
    tick();
    load_pulse(16'h4444, 4'h0);
    sync_frame();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_m[k] !== 7'h33) begin tests_failed++; $display("FAIL back_to_back d%0d got=%h exp=33", k, got_m[k]); end
    end
  endtask

  task automatic test_polarity();
    logic [6:0] inv_exp [4];
    inv_exp = '{7'h01, 7'h38, 7'h60, 7'h0F};
    dec = 1'b0; blank = 1'b0;
    load_pulse(16'h7BF0, 4'b0100);
    sync_frame();
    for (int k = 0; k < 4; k++) got_p[k] = 'x;
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int k = 0; k < 4; k++) if (p_en == (4'b0001 << k)) got_p[k] = p_seg;
      tests_run++;
      if ($countones(p_en) > 1) begin tests_failed++; $display("FAIL pol_onehot cyc=%0d got=%b exp=at_most_one", i, p_en); end
      tests_run++;
      if (p_dp !== ((p_en == 4'b0100) ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL pol_dp cyc=%0d en=%b got=%b", i, p_en, p_dp); end
      tests_run++;
      if (act_pol !== exp_pol) begin tests_failed++; $display("FAIL pol_model cyc=%0d got=%h exp=%h", i, act_pol, exp_pol); end
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (got_p[k] !== inv_exp[k]) begin tests_failed++; $display("FAIL pol_seg d%0d got=%h exp=%h", k, got_p[k], inv_exp[k]); end
    end
  endtask

  task automatic test_async_reset();
    sync_frame();
    while ((pos_m % 16) != 11) tick();
    tests_run++;
    if (m_en !== 4'b1011) begin tests_failed++; $display("FAIL pre_reset_digit got=%b exp=1011", m_en); end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (act_main !== RST_MAIN) begin tests_failed++; $display("FAIL async_reset main got=%h exp=%h", act_main, RST_MAIN); end
    tests_run++;
    if (act_pol !== RST_POL) begin tests_failed++; $display("FAIL async_reset pol got=%h exp=%h", act_pol, RST_POL); end
    tests_run++;
    if (act_one !== RST_ONE) begin tests_failed++; $display("FAIL async_reset one got=%h exp=%h", act_one, RST_ONE); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (m_en !== 4'b1110) begin tests_failed++; $display("FAIL restart_digit0 got=%b exp=1110", m_en); end
    tests_run++;
    if (act_main !== exp_main) begin tests_failed++; $display("FAIL restart_model got=%h exp=%h", act_main, exp_main); end
    while ((pos_m % 16) != 0) tick();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({got_m[k], gdp_m[k]} !== {7'h7E, 1'b0}) begin tests_failed++; $display("FAIL empty_buffer d%0d got=%h/%b exp=7e/0", k, got_m[k], gdp_m[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp    = 4'($urandom);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) dec = ~dec;
      if ($urandom_range(0, 31) == 0) blank = ~blank;
      tick();
      tests_run++;
      if (act_main !== exp_main) begin tests_failed++; $display("FAIL random main cyc=%0d got=%h exp=%h", i, act_main, exp_main); end
      tests_run++;
      if (act_pol !== exp_pol) begin tests_failed++; $display("FAIL random pol cyc=%0d got=%h exp=%h", i, act_pol, exp_pol); end
      tests_run++;
      if (act_one !== exp_one) begin tests_failed++; $display("FAIL random one cyc=%0d got=%h exp=%h", i, act_one, exp_one); end
    end
    load = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_table();
    test_blanking();
    test_frame_buffer();
    test_polarity();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
